sccb_arbiter: RTL and testbench

Shares the single SCCB byte engine (sccb_core) between N_REQ transaction-level requesters, for example the init sequencer and a runtime exposure/AWB tuner.
- Arbitrates round-robin and grants one whole register transaction at a time.
- Sequences the SCCB bytes of that transaction: write = ID, addrH, addrL, data; read = ID, addrH, addrL, stop, then ID|1 and receive one byte.
- Returns done/error and read data to the granted requester.

---
 rtl/sccb_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/sccb_arbiter.sv | 258 +++++++++++++++++++++++++
 tb/tb_sccb_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
// sccb_pkg: state encoding, byte indices and ID helpers shared by the
// SCCB transaction arbiter and its round-robin picker.
package sccb_pkg;

    localparam logic [7:0] CAM_ADDRESS_DEFAULT = 8'h78;

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_ARB   = 3'd1;
    localparam logic [STATE_W-1:0] ST_SEND  = 3'd2;
    localparam logic [STATE_W-1:0] ST_WACK  = 3'd3;
    localparam logic [STATE_W-1:0] ST_RSEND = 3'd4;
    localparam logic [STATE_W-1:0] ST_WRX   = 3'd5;
    localparam logic [STATE_W-1:0] ST_FIN   = 3'd6;
    localparam logic [STATE_W-1:0] ST_TOUT  = 3'd7;

    // Index of the byte currently on the wire within one register transaction.
    localparam int BYTE_CNT_W = 2;
    localparam logic [BYTE_CNT_W-1:0] BYTE_IDX_ID    = 2'd0;
    localparam logic [BYTE_CNT_W-1:0] BYTE_IDX_ADDRH = 2'd1;
    localparam logic [BYTE_CNT_W-1:0] BYTE_IDX_ADDRL = 2'd2;
    localparam logic [BYTE_CNT_W-1:0] BYTE_IDX_DATA  = 2'd3;

    // The SCCB read ID is the write ID with the R/W bit set.
    function automatic logic [7:0] readId(input logic [7:0] writeId);
        return writeId | 8'h01;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker. Searches the request vector
// starting at the pointer and wrapping modulo N_REQ; the pointer register
// lives in the caller.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    input  logic             en_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] sum;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Walk the requesters in rotation order from the pointer and keep the first hit.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        found   = 1'b0;
        sum     = '0;
        cand    = '0;
        if (en_i) begin
            for (int k = 0; k < N_REQ; k++) begin
                sum = {1'b0, ptr_i} + SUM_W'(k);
                if (sum >= SUM_W'(N_REQ)) begin
                    sum = sum - SUM_W'(N_REQ);
                end
                cand = sum[IDX_W-1:0];
                if (!found && req_i[cand]) begin
                    found       = 1'b1;
                    idx_o       = cand;
                    gnt_o[cand] = 1'b1;
                end
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/sccb_arbiter.sv
// sccb_arbiter: shares one SCCB byte engine between N_REQ register-level
// requesters. Grants a whole transaction round-robin, sequences its bytes
// into the core, and returns done/err/rdata to the winner.
module sccb_arbiter
    import sccb_pkg::*;
#(
    parameter int         N_REQ          = 2,
    parameter logic [7:0] CAM_ADDRESS    = CAM_ADDRESS_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 200000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [N_REQ-1:0]     i_req_we,
    input  logic [16*N_REQ-1:0]  i_req_addr,
    input  logic [8*N_REQ-1:0]   i_req_wdata,
    output logic [N_REQ-1:0]     o_gnt,
    output logic [N_REQ-1:0]     o_done,
    output logic                 o_err,
    output logic [7:0]           o_rdata,
    output logic                 o_busy,
    output logic [7:0]           o_core_tx_data,
    output logic                 o_core_start,
    output logic                 o_core_stop,
    input  logic                 i_core_tx_ready,
    input  logic                 i_core_ack,
    input  logic                 i_core_rx_ready,
    input  logic [7:0]           i_core_rx_data
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [STATE_W-1:0]    state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [IDX_W-1:0]      win_q, win_d;
    logic                  we_q, we_d;
    logic [15:0]           addr_q, addr_d;
    logic [7:0]            wdata_q, wdata_d;
    logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [N_REQ-1:0]      gnt_q, gnt_d;
    logic [N_REQ-1:0]      done_q, done_d;
    logic                  err_q, err_d;
    logic [7:0]            rdata_q, rdata_d;
    logic [7:0]            txd_q, txd_d;
    logic                  start_q, start_d;
    logic                  stop_q, stop_d;

    logic [N_REQ-1:0]      arbGnt;
    logic [IDX_W-1:0]      arbIdx;
    logic                  arbValid;
    logic                  arbEn;
    logic                  timedState;
    logic                  tmoHit;
    logic                  takeTimeout;
    logic [IDX_W-1:0]      ptrNext;

    // Arbitration is held off during the done cycle so the finishing requester,
    // which still holds i_req that cycle, cannot immediately win again.
    assign arbEn = (state_q == ST_IDLE) && (done_q == '0);

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i   (i_req),
        .ptr_i   (ptr_q),
        .en_i    (arbEn),
        .gnt_o   (arbGnt),
        .idx_o   (arbIdx),
        .valid_o (arbValid)
    );

    assign timedState = (state_q == ST_SEND) || (state_q == ST_WACK) ||
                        (state_q == ST_RSEND) || (state_q == ST_WRX) ||
                        (state_q == ST_FIN);
    assign tmoHit  = timedState && (tmo_q == TMO_LAST);
    assign ptrNext = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;

    // Transaction sequencer: next-state, byte selection, pulses and timeout.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        txd_d       = txd_q;
        start_d     = 1'b0;
        stop_d      = 1'b0;
        takeTimeout = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (done_q != '0) begin
                    gnt_d = '0;
                end else if (arbValid) begin
                    win_d = arbIdx;
                    gnt_d = arbGnt;
                    for (int k = 0; k < N_REQ; k++) begin
                        if (arbGnt[k]) begin
                            we_d    = i_req_we[k];
                            addr_d  = i_req_addr[16*k +: 16];
                            wdata_d = i_req_wdata[8*k +: 8];
                        end
                    end
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                txd_d   = CAM_ADDRESS;
                cnt_d   = BYTE_IDX_ID;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (i_core_tx_ready) begin
                    start_d = 1'b1;
                    state_d = ST_WACK;
                end else begin
                    takeTimeout = tmoHit;
                end
            end
            ST_WACK: begin
                if (i_core_ack) begin
                    case (cnt_q)
                        BYTE_IDX_ID: begin
                            txd_d   = addr_q[15:8];
                            cnt_d   = BYTE_IDX_ADDRH;
                            state_d = ST_SEND;
                        end
                        BYTE_IDX_ADDRH: begin
                            txd_d   = addr_q[7:0];
                            cnt_d   = BYTE_IDX_ADDRL;
                            state_d = ST_SEND;
                        end
                        BYTE_IDX_ADDRL: begin
                            if (we_q) begin
                                txd_d   = wdata_q;
                                cnt_d   = BYTE_IDX_DATA;
                                state_d = ST_SEND;
                            end else begin
                                stop_d  = 1'b1;
                                txd_d   = readId(CAM_ADDRESS);
                                state_d = ST_RSEND;
                            end
                        end
                        default: begin
                            stop_d  = 1'b1;
                            state_d = ST_FIN;
                        end
                    endcase
                end else begin
                    takeTimeout = tmoHit;
                end
            end
            ST_RSEND: begin
                if (i_core_tx_ready && !stop_q) begin
                    start_d = 1'b1;
                    state_d = ST_WRX;
                end else begin
                    takeTimeout = tmoHit;
                end
            end
            ST_WRX: begin
                if (i_core_rx_ready) begin
                    rdata_d = i_core_rx_data;
                    state_d = ST_FIN;
                end else begin
                    takeTimeout = tmoHit;
                end
            end
            ST_FIN: begin
                if (i_core_tx_ready && !stop_q) begin
                    done_d  = gnt_q;
                    ptr_d   = ptrNext;
                    state_d = ST_IDLE;
                end else begin
                    takeTimeout = tmoHit;
                end
            end
            ST_TOUT: begin
                gnt_d   = '0;
                ptr_d   = ptrNext;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (takeTimeout) begin
            stop_d  = 1'b1;
            done_d  = gnt_q;
            err_d   = 1'b1;
            state_d = ST_TOUT;
        end

        if (timedState && (state_d == state_q)) begin
            tmo_d = tmo_q + 1'b1;
        end else begin
            tmo_d = '0;
        end
    end

    // State and output registers; reset abandons any transaction without a stop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            txd_q   <= CAM_ADDRESS;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            txd_q   <= txd_d;
            start_q <= start_d;
            stop_q  <= stop_d;
        end
    end

    assign o_gnt          = gnt_q;
    assign o_done         = done_q;
    assign o_err          = err_q;
    assign o_rdata        = rdata_q;
    assign o_busy         = (state_q != ST_IDLE);
    assign o_core_tx_data = txd_q;
    assign o_core_start   = start_q;
    assign o_core_stop    = stop_q;

endmodule

// File: tb/tb_sccb_arbiter.sv
// tb_sccb_arbiter: drives the arbiter with directed and random register
// transactions through a behavioural SCCB core model, and predicts bus bytes,
// grant order, done/err and read data from transaction-level rules.
module tb_sccb_arbiter;

    localparam int         N       = 3;
    localparam logic [7:0] TB_CAM  = 8'h78;
    localparam int         TMO     = 100;
    localparam logic [8:0] STOP_MK = 9'h100;

    localparam int CM_IDLE = 0;
    localparam int CM_ACK  = 1;
    localparam int CM_RX   = 2;
    localparam int CM_STOP = 3;
    localparam int CM_HANG = 4;

    logic            clk;
    logic            rstN;
    logic [N-1:0]    iReq;
    logic [N-1:0]    iReqWe;
    logic [16*N-1:0] iReqAddr;
    logic [8*N-1:0]  iReqWdata;
    logic [N-1:0]    oGnt;
    logic [N-1:0]    oDone;
    logic            oErr;
    logic [7:0]      oRdata;
    logic            oBusy;
    logic [7:0]      coreTxData;
    logic            coreStart;
    logic            coreStop;
    logic            coreTxReady;
    logic            coreAck;
    logic            coreRxReady;
    logic [7:0]      coreRxData;

    int checkCount = 0;
    int errorCount = 0;

    logic [8:0]  busLog[$];
    logic [8:0]  expLog[$];
    int          doneOrder[$];

    logic        txWe[N];
    logic [15:0] txAddr[N];
    logic [7:0]  txWdata[N];

    int          refPtr;
    logic [7:0]  refRdata;

    int          coreMode;
    int          busyCnt;
    int          startsInTxn;
    bit          lastWasStop;
    bit          withholdOn;
    int          withholdIdx;
    int          withheldCycle;
    int          cycleCnt = 0;
    bit          forceRx;
    logic [7:0]  coreRxByte;
    logic [7:0]  lastRx;

    sccb_arbiter #(
        .N_REQ          (N),
        .CAM_ADDRESS    (TB_CAM),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rstN),
        .i_req           (iReq),
        .i_req_we        (iReqWe),
        .i_req_addr      (iReqAddr),
        .i_req_wdata     (iReqWdata),
        .o_gnt           (oGnt),
        .o_done          (oDone),
        .o_err           (oErr),
        .o_rdata         (oRdata),
        .o_busy          (oBusy),
        .o_core_tx_data  (coreTxData),
        .o_core_start    (coreStart),
        .o_core_stop     (coreStop),
        .i_core_tx_ready (coreTxReady),
        .i_core_ack      (coreAck),
        .i_core_rx_ready (coreRxReady),
        .i_core_rx_data  (coreRxData)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a bounded wait was somehow skipped.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Behavioural SCCB core: logs every byte start and stop, answers with an
    // ACK or a received byte after a random busy time, can hang on one byte.
    always @(negedge clk) begin
        cycleCnt++;
        if (!rstN) begin
            coreTxReady = 1'b1;
            coreAck     = 1'b0;
            coreRxReady = 1'b0;
            coreMode    = CM_IDLE;
            busyCnt     = 0;
            startsInTxn = 0;
            lastWasStop = 1'b0;
            busLog.delete();
        end else begin
            coreAck     = 1'b0;
            coreRxReady = 1'b0;
            if (coreStart) begin
                checkOutput("stopWithStart", coreStop, 1'b0);
                checkOutput("busyOnStart", oBusy, 1'b1);
                busLog.push_back({1'b0, coreTxData});
                coreTxReady = 1'b0;
                busyCnt     = $urandom_range(1, 4);
                if (withholdOn && startsInTxn == withholdIdx) begin
                    coreMode      = CM_HANG;
                    withheldCycle = cycleCnt;
                end else if (lastWasStop && coreTxData == (TB_CAM | 8'h01)) begin
                    coreMode = CM_RX;
                end else begin
                    coreMode = CM_ACK;
                end
                lastWasStop = 1'b0;
                startsInTxn++;
            end else if (coreStop) begin
                busLog.push_back(STOP_MK);
                lastWasStop = 1'b1;
                coreTxReady = 1'b0;
                coreMode    = CM_STOP;
                busyCnt     = $urandom_range(1, 3);
            end else begin
                case (coreMode)
                    CM_ACK: begin
                        if (busyCnt > 0) busyCnt--;
                        else begin
                            coreAck     = 1'b1;
                            coreTxReady = 1'b1;
                            coreMode    = CM_IDLE;
                        end
                    end
                    CM_RX: begin
                        if (busyCnt > 0) busyCnt--;
                        else begin
                            coreRxData  = forceRx ? coreRxByte : 8'($urandom);
                            lastRx      = coreRxData;
                            coreRxReady = 1'b1;
                            coreMode    = CM_STOP;
                            busyCnt     = 2;
                        end
                    end
                    CM_STOP: begin
                        if (busyCnt > 0) busyCnt--;
                        else begin
                            coreTxReady = 1'b1;
                            coreMode    = CM_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [N-1:0] oneHot(input int idx);
        logic [N-1:0] v;
        v = '0;
        if (idx >= 0 && idx < N) v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin rule: first pending requester at or after the pointer.
    function automatic int refPick(input logic [N-1:0] pend);
        for (int i = 0; i < N; i++) begin
            int c;
            c = (refPtr + i) % N;
            if (pend[c]) return c;
        end
        return -1;
    endfunction

    task automatic setTxn(input int k, input logic we, input logic [15:0] addr, input logic [7:0] wdata);
        txWe[k]    = we;
        txAddr[k]  = addr;
        txWdata[k] = wdata;
        iReqWe[k]  = we;
        iReqAddr[16*k +: 16] = addr;
        iReqWdata[8*k +: 8]  = wdata;
    endtask

    // Bus bytes a register transaction must produce; a timed-out one is cut
    // after the hung byte and closed with the abort stop.
    task automatic buildExp(input int w, input bit timedOut, input int cutIdx);
        expLog.delete();
        expLog.push_back({1'b0, TB_CAM});
        expLog.push_back({1'b0, txAddr[w][15:8]});
        expLog.push_back({1'b0, txAddr[w][7:0]});
        if (txWe[w]) begin
            expLog.push_back({1'b0, txWdata[w]});
            expLog.push_back(STOP_MK);
        end else begin
            expLog.push_back(STOP_MK);
            expLog.push_back({1'b0, TB_CAM | 8'h01});
        end
        if (timedOut) begin
            while (expLog.size() > cutIdx + 1) void'(expLog.pop_back());
            expLog.push_back(STOP_MK);
        end
    endtask

    task automatic checkIdleOutputs();
        checkOutput("rstGnt",   oGnt, '0);
        checkOutput("rstDone",  oDone, '0);
        checkOutput("rstErr",   oErr, 1'b0);
        checkOutput("rstRdata", oRdata, 8'h00);
        checkOutput("rstBusy",  oBusy, 1'b0);
        checkOutput("rstStart", coreStart, 1'b0);
        checkOutput("rstStop",  coreStop, 1'b0);
        checkOutput("rstTx",    coreTxData, TB_CAM);
    endtask

    // Raise the requests in mask and follow every completion until all are done.
    task automatic applyStimulus(input logic [N-1:0] mask, input int mutateK);
        logic [N-1:0] pending;
        int           budget;
        int           w;
        bit           mutated;
        bit           expErr;
        pending = mask;
        budget  = 0;
        mutated = 1'b0;
        doneOrder.delete();
        for (int k = 0; k < N; k++) if (mask[k]) iReq[k] = 1'b1;
        while (pending != '0 && budget < 2000) begin
            @(negedge clk);
            #1;
            budget++;
            if (mutateK >= 0 && !mutated && oGnt[mutateK]) begin
                mutated = 1'b1;
                iReq[mutateK] = 1'b0;
                iReqAddr[16*mutateK +: 16] = ~txAddr[mutateK];
                iReqWdata[8*mutateK +: 8]  = ~txWdata[mutateK];
            end
            if (oDone != '0) begin
                w      = refPick(pending);
                expErr = withholdOn;
                checkOutput("doneVec", oDone, oneHot(w));
                checkOutput("gntAtDone", oGnt, oneHot(w));
                checkOutput("errFlag", oErr, expErr);
                if (w >= 0) begin
                    if (!txWe[w] && !expErr) refRdata = lastRx;
                    checkOutput("rdata", oRdata, refRdata);
                    buildExp(w, expErr, withholdIdx);
                    checkOutput("busLen", busLog.size(), expLog.size());
                    for (int i = 0; i < expLog.size(); i++) begin
                        if (i < busLog.size()) checkOutput($sformatf("busByte%0d", i), busLog[i], expLog[i]);
                    end
                    if (expErr) checkOutput("toutLatency", cycleCnt - withheldCycle, TMO);
                    doneOrder.push_back(w);
                    iReq[w]    = 1'b0;
                    pending[w] = 1'b0;
                    refPtr     = (w + 1) % N;
                end
                busLog.delete();
                startsInTxn = 0;
                withholdOn  = 1'b0;
            end
        end
        checkOutput("batchComplete", pending, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkOutput("noExtraDone", oDone, '0);
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        #1;
        rstN = 1'b0;
        iReq = '0;
        #1;
        checkIdleOutputs();
        repeat (2) @(negedge clk);
        #1;
        rstN     = 1'b1;
        refPtr   = 0;
        refRdata = 8'h00;
    endtask

    initial begin
        int budget;
        rstN        = 1'b0;
        iReq        = '0;
        iReqWe      = '0;
        iReqAddr    = '0;
        iReqWdata   = '0;
        coreTxReady = 1'b1;
        coreAck     = 1'b0;
        coreRxReady = 1'b0;
        coreRxData  = 8'h00;
        withholdOn  = 1'b0;
        withholdIdx = 0;
        forceRx     = 1'b0;
        coreRxByte  = 8'h00;
        lastRx      = 8'h00;
        refPtr      = 0;
        refRdata    = 8'h00;
        for (int k = 0; k < N; k++) setTxn(k, 1'b1, 16'h0000, 8'h00);

        repeat (3) @(negedge clk);
        #1;
        checkIdleOutputs();
        rstN = 1'b1;

        $display("[TB] write 0x3008=0x82 from requester 0");
        setTxn(0, 1'b1, 16'h3008, 8'h82);
        applyStimulus(3'b001, -1);

        $display("[TB] read 0x300A from requester 1");
        forceRx    = 1'b1;
        coreRxByte = 8'h56;
        setTxn(1, 1'b0, 16'h300A, 8'h00);
        applyStimulus(3'b010, -1);
        checkOutput("rdata56", oRdata, 8'h56);
        forceRx = 1'b0;

        $display("[TB] round-robin from reset");
        applyReset();
        setTxn(0, 1'b1, 16'h1111, 8'h11);
        setTxn(1, 1'b1, 16'h2222, 8'h22);
        applyStimulus(3'b011, -1);
        checkOutput("rrLenA", doneOrder.size(), 2);
        if (doneOrder.size() == 2) begin
            checkOutput("rrFirstA", doneOrder[0], 0);
            checkOutput("rrSecondA", doneOrder[1], 1);
        end
        applyStimulus(3'b001, -1);
        applyStimulus(3'b011, -1);
        checkOutput("rrLenB", doneOrder.size(), 2);
        if (doneOrder.size() == 2) begin
            checkOutput("rrFirstB", doneOrder[0], 1);
            checkOutput("rrSecondB", doneOrder[1], 0);
        end

        $display("[TB] timeout on withheld ACK of byte 2");
        setTxn(0, 1'b1, 16'h3008, 8'h82);
        withholdIdx = 2;
        withholdOn  = 1'b1;
        applyStimulus(3'b001, -1);
        checkOutput("timeoutCleared", withholdOn, 1'b0);
        setTxn(1, 1'b0, 16'h4455, 8'h00);
        applyStimulus(3'b010, -1);

        $display("[TB] requester changes inputs and drops request mid-write");
        setTxn(0, 1'b1, 16'h5A5A, 8'h3C);
        applyStimulus(3'b001, 0);

        $display("[TB] reset during WACK");
        setTxn(0, 1'b1, 16'h1234, 8'hA5);
        iReq[0] = 1'b1;
        budget  = 0;
        while (busLog.size() < 2 && budget < 500) begin
            @(negedge clk);
            #1;
            budget++;
        end
        checkOutput("reachWack", busLog.size() >= 2, 1'b1);
        #1;
        rstN = 1'b0;
        #1;
        checkIdleOutputs();
        repeat (2) @(negedge clk);
        #1;
        rstN     = 1'b1;
        refPtr   = 0;
        refRdata = 8'h00;
        applyStimulus(3'b001, -1);

        $display("[TB] random transactions");
        for (int it = 0; it < 25; it++) begin
            for (int k = 0; k < N; k++) begin
                setTxn(k, 1'($urandom), 16'($urandom), 8'($urandom));
            end
            applyStimulus(3'($urandom_range(1, 7)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
